// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: parks a fetched packet while decode is stalled,
// because the SRAM output is only valid for one cycle after the read.
module fetch_skid_buf
  import rv_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  fetch_pkt_t i_pkt,
  input  logic       i_ready,
  input  logic       i_flush,
  output logic       o_valid,
  output fetch_pkt_t o_pkt
);

  logic       hold_valid_q, hold_valid_d;
  fetch_pkt_t hold_pkt_q, hold_pkt_d;

  // Flush beats drain, drain beats capture; capture only into an empty slot.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_pkt_d   = hold_pkt_q;
    if (i_flush) begin
      hold_valid_d = 1'b0;
    end else if (hold_valid_q) begin
      hold_valid_d = ~i_ready;
    end else if (i_valid && !i_ready) begin
      hold_valid_d = 1'b1;
      hold_pkt_d   = i_pkt;
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_valid_q <= 1'b0;
      hold_pkt_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pkt_q   <= hold_pkt_d;
    end
  end

  assign o_valid = hold_valid_q;
  assign o_pkt   = hold_pkt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle synchronous imem
// and delivers {pc, instr} to decode, with redirect and back-pressure handling.
module ifetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_ADDR_WIDTH = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_read,
  output logic        o_imem_write,
  output logic [3:0]  o_imem_size,
  input  logic [31:0] i_imem_rd_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  input  logic        i_ready
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        issue_s;
  logic [31:0] issue_addr_s;
  logic        hold_valid_s;
  fetch_pkt_t  hold_pkt_s;
  fetch_pkt_t  rsp_pkt_s;
  logic        out_valid_s;
  logic        unused_s;

  // Address bits above MEM_ADDR_WIDTH alias inside imem; fetch never range-checks.
  assign unused_s = (^i_redirect_pc[1:0]) ^ (MEM_ADDR_WIDTH == 0);

  assign issue_s      = i_redirect | i_ready | ~(hold_valid_s | rsp_valid_q);
  assign issue_addr_s = i_redirect ? word_align(i_redirect_pc) : pc_q;

  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = 1'b0;
    if (issue_s) begin
      pc_d        = issue_addr_s + INSTR_BYTES;
      rsp_pc_d    = issue_addr_s;
      rsp_valid_d = 1'b1;
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_pkt_s = '{pc: rsp_pc_q, instr: i_imem_rd_data};

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (rsp_valid_q & ~i_redirect),
    .i_pkt   (rsp_pkt_s),
    .i_ready (i_ready),
    .i_flush (i_redirect),
    .o_valid (hold_valid_s),
    .o_pkt   (hold_pkt_s)
  );

  // A redirect kills whatever is on the output this cycle.
  assign out_valid_s  = (hold_valid_s | rsp_valid_q) & ~i_redirect;
  assign o_valid      = out_valid_s;
  assign o_pc         = hold_valid_s ? hold_pkt_s.pc : rsp_pc_q;
  assign o_instr      = out_valid_s ? (hold_valid_s ? hold_pkt_s.instr : i_imem_rd_data)
                                    : INSTR_NOP;

  assign o_imem_read  = issue_s & i_rst_n;
  assign o_imem_addr  = issue_s ? issue_addr_s : pc_q;
  assign o_imem_write = 1'b0;
  assign o_imem_size  = 4'b1111;

endmodule
